// File: rtl/ntt_seq_pkg.sv
// Shared constants, state encoding and error-bit indices for the NTT frame sequencer.
package ntt_seq_pkg;
  localparam int DW_DEF           = 28;
  localparam int IPC_DEF          = 128;
  localparam int N_DEF            = 4096;
  localparam int NUM_STAGES_DEF   = 11;
  localparam int STAGE_LAT_DEF    = 40;
  localparam int MAX_INFLIGHT_DEF = 4;

  localparam int BEATS      = N_DEF / IPC_DEF;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int INFLIGHT_W = $clog2(MAX_INFLIGHT_DEF + 1);

  localparam int ERR_W        = 3;
  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_SPURIOUS = 1;
  localparam int ERR_OVERLAP  = 2;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} seq_state_t;
endpackage

// File: rtl/ntt_frame_sequencer_if.sv
// Host stream, datapath and result-framing signals of the NTT frame sequencer.
interface ntt_frame_sequencer_if #(
  parameter int DW         = 28,
  parameter int IPC        = 128,
  parameter int NUM_STAGES = 11
);
  logic                           in_valid;
  logic                           in_ready;
  logic [IPC-1:0][DW-1:0]         in_data;
  logic [IPC-1:0][DW-1:0]         dp_data;
  logic [NUM_STAGES-1:0]          dp_start;
  logic [NUM_STAGES-1:0]          dp_out_start;
  logic                           out_valid;
  logic                           out_first;
  logic                           out_last;

  modport slave (
    input  in_valid, in_data, dp_out_start,
    output in_ready, dp_data, dp_start, out_valid, out_first, out_last
  );
  modport master (
    output in_valid, in_data, dp_out_start,
    input  in_ready, dp_data, dp_start, out_valid, out_first, out_last
  );
endinterface

// File: rtl/ntt_pulse_delay.sv
// Fixed-depth single-bit delay line; several pulses may be in flight at once.
module ntt_pulse_delay #(
  parameter int DEPTH = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= d;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH];
endmodule

// File: rtl/ntt_frame_sequencer.sv
// Frame controller in front of the non-stallable NTT pipeline: frames input beats,
// fans out stage starts and frames the result stream. NTT_SEQ_PERF_EN adds perf counters.
module ntt_frame_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int DATA_WIDTH_PER_INPUT = DW_DEF,
  parameter int INPUT_PER_CYCLE      = IPC_DEF,
  parameter int N                    = N_DEF,
  parameter int NUM_STAGES           = NUM_STAGES_DEF,
  parameter int STAGE_LAT            = STAGE_LAT_DEF,
  parameter int MAX_INFLIGHT         = MAX_INFLIGHT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ntt_frame_sequencer_if.slave bus,
  output logic              busy,
  output logic [ERR_W-1:0]  err
`ifdef NTT_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_frames_in,
  output logic [31:0]       perf_frames_out,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int NB    = N / INPUT_PER_CYCLE;
  localparam int NB_W  = $clog2(NB);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [NB_W-1:0]  LAST_BEAT = NB_W'(NB - 1);
  localparam logic [INF_W-1:0] INF_MAX   = INF_W'(MAX_INFLIGHT);

  seq_state_t            state, state_nxt;
  logic [NB_W-1:0]       beat_cnt, beat_cnt_nxt;
  logic [INF_W-1:0]      inflight, inflight_nxt;
  logic                  live, room, inc, dec, beat_vld;
  logic                  start0, strb_q, strb_rise;
  logic                  out_active;
  logic [NB_W-1:0]       out_cnt;
  logic [NUM_STAGES-1:0] start_chain;

  // live holds in_ready low until the first edge after reset release
  assign room = (inflight < INF_MAX);
  assign inc  = live && (state == IDLE) && bus.in_valid && room;
  assign dec  = bus.out_last && (inflight != '0);

  always_comb begin
    inflight_nxt = inflight;
    case ({inc, dec})
      2'b10:   inflight_nxt = inflight + 1'b1;
      2'b01:   inflight_nxt = inflight - 1'b1;
      default: inflight_nxt = inflight;
    endcase
  end

  // Back-to-back frames re-enter through IDLE, which accepts in the same cycle,
  // so the next frame's first beat follows the last beat with no bubble.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    bus.in_ready = 1'b0;
    beat_vld     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = live && room;
        if (inc) begin
          beat_vld     = 1'b1;
          beat_cnt_nxt = NB_W'(1);
          state_nxt    = STREAM;
        end
      end
      STREAM: begin
        bus.in_ready = 1'b1;
        beat_vld     = bus.in_valid;
        beat_cnt_nxt = beat_cnt + 1'b1;
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign strb_rise = bus.dp_out_start[NUM_STAGES-1] && !strb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= 1'b0;
      state       <= IDLE;
      beat_cnt    <= '0;
      inflight    <= '0;
      bus.dp_data <= '0;
      start0      <= 1'b0;
      strb_q      <= 1'b0;
      out_active  <= 1'b0;
      out_cnt     <= '0;
      err         <= '0;
    end else begin
      live        <= 1'b1;
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      inflight    <= inflight_nxt;
      bus.dp_data <= beat_vld ? bus.in_data : '0;
      start0      <= inc;
      strb_q      <= bus.dp_out_start[NUM_STAGES-1];
      if (state == STREAM && !bus.in_valid) err[ERR_UNDERRUN] <= 1'b1;
      if (out_active) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_cnt == LAST_BEAT) out_active <= 1'b0;
        if (strb_rise) err[ERR_OVERLAP] <= 1'b1;
      end else if (strb_rise) begin
        if (inflight == '0) begin
          err[ERR_SPURIOUS] <= 1'b1;
        end else begin
          out_active <= 1'b1;
          out_cnt    <= '0;
        end
      end
    end
  end

  assign start_chain[0] = start0;

  ntt_pulse_delay #(.DEPTH(STAGE_LAT)) u_dly [NUM_STAGES-2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start_chain[NUM_STAGES-2:0]),
    .q     (start_chain[NUM_STAGES-1:1])
  );

  assign bus.dp_start  = start_chain;
  assign bus.out_valid = out_active;
  assign bus.out_first = out_active && (out_cnt == '0);
  assign bus.out_last  = out_active && (out_cnt == LAST_BEAT);
  assign busy          = (inflight != '0) || (state != IDLE);

`ifdef NTT_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_frames_in    <= '0;
      perf_frames_out   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (inc)          perf_frames_in  <= perf_frames_in + 32'd1;
      if (bus.out_last) perf_frames_out <= perf_frames_out + 32'd1;
      if (state == IDLE && bus.in_valid && !bus.in_ready)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ntt_frame_sequencer.sv
// Self-checking bench for ntt_frame_sequencer: per-cycle reference model plus directed scenarios.
module tb_ntt_frame_sequencer;
  localparam int DW = 28, IPC = 128, NS = 11, LAT = 40, MAXF = 4, BEATS = 32;
  typedef logic [IPC-1:0][DW-1:0] beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] err;
`ifdef NTT_SEQ_PERF_EN
  logic [31:0] pf_in, pf_out, pf_stall;
`endif

  always #5 clk = ~clk;

  ntt_frame_sequencer_if #(.DW(DW), .IPC(IPC), .NUM_STAGES(NS)) bus ();

  ntt_frame_sequencer #(
    .DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N(IPC*BEATS),
    .NUM_STAGES(NS), .STAGE_LAT(LAT), .MAX_INFLIGHT(MAXF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
`ifdef NTT_SEQ_PERF_EN
    ,
    .perf_frames_in    (pf_in),
    .perf_frames_out   (pf_out),
    .perf_stall_cycles (pf_stall)
`endif
  );

  int checks = 0, errors = 0;

  // reference model: frame position, frames in flight, start timestamps, output beat index
  int         cyc = 0;
  int         m_pos = -1, m_ob = -1, m_infl = 0;
  bit         m_live = 0, m_prev = 0;
  logic [2:0] m_err = '0;
  beat_t      m_data = '0;
  int         sq[$];

  int n_outv = 0, n_first = 0, n_last = 0, first_cyc = 0, last_cyc = 0, acc_cyc = 0;
  int n_start[NS];
  int start_cyc[NS];

  typedef struct { int nfr; int exp_frames; bit exp_rdy; } t3_vec_t;
  t3_vec_t tv[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string nm, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s act[1:0]=%0h exp[1:0]=%0h (cyc %0d)", nm, act[1:0], exp[1:0], cyc);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < IPC; i++) b[i] = DW'($urandom);
    return b;
  endfunction

  task automatic model_step();
    logic [NS-1:0] es;
    beat_t nd;
    bit v, strb, inc, dec, rise, rdy;
    int pn, obn;
    if (!rst_n) begin
      chk("rst_outs", {bus.in_ready, bus.dp_start, bus.out_valid, bus.out_first, bus.out_last, busy, err}, 0);
      chk_data("rst_data", bus.dp_data, '0);
      m_pos = -1; m_ob = -1; m_infl = 0; m_live = 0; m_prev = 0; m_err = '0; m_data = '0;
      sq.delete();
    end else begin
      for (int k = 0; k < NS; k++) begin
        es[k] = 1'b0;
        foreach (sq[i]) if (cyc == sq[i] + k*LAT) es[k] = 1'b1;
      end
      rdy = m_live && ((m_pos < 0) ? (m_infl < MAXF) : 1'b1);
      chk("in_ready", bus.in_ready, rdy);
      chk_data("dp_data", bus.dp_data, m_data);
      chk("dp_start", bus.dp_start, es);
      chk("out_valid", bus.out_valid, m_ob >= 0);
      chk("out_first", bus.out_first, m_ob == 0);
      chk("out_last", bus.out_last, m_ob == BEATS-1);
      chk("busy", busy, (m_infl != 0) || (m_pos >= 0));
      chk("err", err, m_err);
      if (bus.out_valid) n_outv++;
      if (bus.out_first) begin n_first++; first_cyc = cyc; end
      if (bus.out_last)  begin n_last++;  last_cyc  = cyc; end
      for (int k = 0; k < NS; k++) if (bus.dp_start[k]) begin n_start[k]++; start_cyc[k] = cyc; end

      v = bus.in_valid; strb = bus.dp_out_start[NS-1];
      inc = 0; nd = '0; pn = m_pos; obn = m_ob;
      if (m_pos < 0) begin
        if (rdy && v) begin inc = 1; nd = bus.in_data; pn = 1; sq.push_back(cyc + 1); acc_cyc = cyc; end
      end else begin
        if (v) nd = bus.in_data; else m_err[0] = 1'b1;
        pn = (m_pos == BEATS-1) ? -1 : m_pos + 1;
      end
      dec  = (m_ob == BEATS-1);
      rise = strb && !m_prev;
      if (m_ob >= 0) begin
        obn = (m_ob == BEATS-1) ? -1 : m_ob + 1;
        if (rise) m_err[2] = 1'b1;
      end else if (rise) begin
        if (m_infl == 0) m_err[1] = 1'b1; else obn = 0;
      end
      m_infl = m_infl + int'(inc) - int'(dec);
      m_pos = pn; m_ob = obn; m_prev = strb; m_live = 1; m_data = nd;
      while (sq.size() > 0 && cyc > sq[0] + (NS-1)*LAT) void'(sq.pop_front());
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    bus.dp_out_start = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int bubble);
    for (int b = 0; b < BEATS; b++) begin
      bus.in_valid = (b != bubble);
      bus.in_data  = rand_beat();
      tick();
      if (b == bubble) chk("bubble_data", |bus.dp_data, 0);
    end
    idle_in();
  endtask

  task automatic strobe();
    bus.dp_out_start[NS-1] = 1'b1;
    tick();
    bus.dp_out_start = '0;
  endtask

  initial begin
    int b0, f0, l0, s0;
    for (int k = 0; k < NS; k++) begin n_start[k] = 0; start_cyc[k] = 0; end
    idle_in();
    bus.dp_out_start = '0;
    tv[0] = '{nfr: 1, exp_frames: 1, exp_rdy: 1'b1};
    tv[1] = '{nfr: 3, exp_frames: 3, exp_rdy: 1'b1};
    tv[2] = '{nfr: 4, exp_frames: 4, exp_rdy: 1'b0};
    tv[3] = '{nfr: 5, exp_frames: 4, exp_rdy: 1'b0};

    // single frame: stage strobe timing
    do_reset();
    repeat (2) tick();
    send_frame(-1);
    repeat (LAT*NS + 10) tick();
    for (int k = 0; k < NS; k++) chk($sformatf("t1_start%0d", k), start_cyc[k] - acc_cyc, 1 + LAT*k);
    chk("t1_ready", bus.in_ready, 1);

    // loopback result frame
    b0 = n_outv; f0 = n_first; l0 = n_last;
    strobe();
    repeat (40) tick();
    chk("t2_beats", n_outv - b0, BEATS);
    chk("t2_first", n_first - f0, 1);
    chk("t2_last", n_last - l0, 1);
    chk("t2_span", last_cyc - first_cyc, BEATS-1);
    chk("t2_busy", busy, 0);

    // back-to-back frames against the in-flight limit
    for (int t = 0; t < 4; t++) begin
      do_reset();
      tick();
      s0 = n_start[0];
      bus.in_valid = 1'b1;
      repeat (tv[t].nfr * BEATS) begin bus.in_data = rand_beat(); tick(); end
      idle_in();
      tick();
      chk($sformatf("t3_frames_%0d", t), n_start[0] - s0, tv[t].exp_frames);
      chk($sformatf("t3_ready_%0d", t), bus.in_ready, tv[t].exp_rdy);
      strobe();
      repeat (40) tick();
      chk($sformatf("t3_reopen_%0d", t), bus.in_ready, 1);
    end

    // bubble on beat 10
    do_reset();
    tick();
    send_frame(10);
    chk("t4_err", err, 3'b001);
    b0 = n_outv;
    strobe();
    repeat (40) tick();
    chk("t4_beats", n_outv - b0, BEATS);
    chk("t4_busy", busy, 0);

    // spurious and overlapping result strobes
    do_reset();
    tick();
    b0 = n_outv;
    strobe();
    repeat (3) tick();
    chk("t5_spur_err", err, 3'b010);
    chk("t5_spur_out", n_outv - b0, 0);
    send_frame(-1);
    b0 = n_outv;
    strobe();
    repeat (5) tick();
    strobe();
    repeat (40) tick();
    chk("t5_ovl_err", err, 3'b110);
    chk("t5_ovl_beats", n_outv - b0, BEATS);
    chk("t5_busy", busy, 0);

    // asynchronous reset mid-frame with two frames in flight
    do_reset();
    tick();
    send_frame(-1);
    bus.in_valid = 1'b1;
    for (int b = 0; b < 15; b++) begin bus.in_data = rand_beat(); tick(); end
    bus.in_data = rand_beat();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {bus.in_ready, bus.dp_start, bus.out_valid, bus.out_first, bus.out_last, busy, err}, 0);
    chk("t6_async_data", |bus.dp_data, 0);
    idle_in();
    repeat (3) tick();
    rst_n = 1'b1;
    s0 = 0;
    for (int k = 0; k < NS; k++) s0 += n_start[k];
    b0 = n_outv;
    repeat (LAT*NS + 40) tick();
    f0 = 0;
    for (int k = 0; k < NS; k++) f0 += n_start[k];
    chk("t6_no_strobes", f0 - s0, 0);
    chk("t6_no_out", n_outv - b0, 0);

    // randomized traffic against the model
    do_reset();
    tick();
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom_range(0, 15) != 0);
      bus.in_data  = rand_beat();
      bus.dp_out_start = NS'($urandom) & {1'b0, {(NS-1){1'b1}}};
      bus.dp_out_start[NS-1] = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle_in();
    bus.dp_out_start = '0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
